// File: rtl/register_file_pkg.sv
// Shared sizing constants for the datapath register file.
// No logic; imported by the top and its storage element.
// No flow control.
package register_file_pkg;

    localparam int REG_COUNT     = 16;
    localparam int REG_WIDTH     = 16;
    localparam int REG_IDX_WIDTH = 4;

endpackage

// File: rtl/register_file_register16.sv
// One 16-bit storage register with synchronous reset and write enable.
// Latency: d appears on q one rising edge after en is sampled high.
// No backpressure; a write is accepted on every enabled edge.
module register16
    import register_file_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic [REG_WIDTH-1:0] d_i,
    output logic [REG_WIDTH-1:0] q_o
);

    logic [REG_WIDTH-1:0] data_q;
    logic [REG_WIDTH-1:0] data_d;

    // Hold the current value unless a write is enabled.
    always_comb begin
        data_d = data_q;
        if (en_i) begin
            data_d = d_i;
        end
    end

    // Reset wins over a simultaneous write.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/register_file.sv
// 16x16 register file, two combinational read ports, one write port, R0 tied to zero.
// Latency: reads 0 cycles; writes stored on the next edge and bypassed to reads at once.
// No backpressure; reads are always enabled and the read ports are always driven.
module register_file
    import register_file_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     WriteReg,
    input  logic [REG_IDX_WIDTH-1:0] SrcReg1,
    input  logic [REG_IDX_WIDTH-1:0] SrcReg2,
    input  logic [REG_IDX_WIDTH-1:0] DstReg,
    input  logic [REG_WIDTH-1:0]     DstData,
    inout  wire  [REG_WIDTH-1:0]     SrcData1,
    inout  wire  [REG_WIDTH-1:0]     SrcData2
);

    logic [REG_COUNT-1:1]                wr_sel;
    logic [REG_COUNT-1:0][REG_WIDTH-1:0] reg_q;
    logic [REG_WIDTH-1:0]                rd1;
    logic [REG_WIDTH-1:0]                rd2;
    logic                                wr_live;

    // R0 is a constant rather than storage.
    assign reg_q[0] = '0;

    // One-hot write decode gated by WriteReg; index 0 has no register behind it.
    always_comb begin
        wr_sel = '0;
        for (int i = 1; i < REG_COUNT; i++) begin
            wr_sel[i] = WriteReg && (DstReg == REG_IDX_WIDTH'(i));
        end
    end

    for (genvar g = 1; g < REG_COUNT; g++) begin : g_regs
        register16 u_reg (
            .clk  (clk),
            .rst  (rst),
            .en_i (wr_sel[g]),
            .d_i  (DstData),
            .q_o  (reg_q[g])
        );
    end

    // A write to R0 is discarded, so it must never bypass either.
    assign wr_live = WriteReg && (DstReg != '0);

    // Each port picks storage, then overrides with in-flight write data on a match.
    always_comb begin
        rd1 = reg_q[SrcReg1];
        rd2 = reg_q[SrcReg2];
        if (wr_live && (SrcReg1 == DstReg)) begin
            rd1 = DstData;
        end
        if (wr_live && (SrcReg2 == DstReg)) begin
            rd2 = DstData;
        end
    end

    assign SrcData1 = rd1;
    assign SrcData2 = rd2;

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

    logic        clk;
    logic        rst;
    logic        we;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [3:0]  dst;
    logic [15:0] dat;
    wire  [15:0] src_data1;
    wire  [15:0] src_data2;

    int checks   = 0;
    int failures = 0;

    logic [15:0] model [16];

    register_file dut (
        .clk      (clk),
        .rst      (rst),
        .WriteReg (we),
        .SrcReg1  (s1),
        .SrcReg2  (s2),
        .DstReg   (dst),
        .DstData  (dat),
        .SrcData1 (src_data1),
        .SrcData2 (src_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [3:0]  dst;
        logic [15:0] dat;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic [15:0] e1;
        logic [15:0] e2;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference read: what a port shows given the architectural register state.
    function automatic logic [15:0] ref_read(input logic [3:0] src);
        if (we && dst != 4'd0 && src == dst) return dat;
        if (src == 4'd0) return 16'h0000;
        return model[src];
    endfunction

    // Reference commit at a rising edge.
    task automatic ref_commit();
        if (rst) begin
            for (int k = 0; k < 16; k++) model[k] = 16'h0000;
        end else if (we && dst != 4'd0) begin
            model[dst] = dat;
        end
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; s1 = 4'd0; s2 = 4'd0; dst = 4'd0; dat = 16'h0;
        for (int k = 0; k < 16; k++) model[k] = 16'h0000;

        // Reset, then sweep both ports across every index.
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s1 = 4'(i);
            s2 = 4'(15 - i);
            #1;
            check("reset_rd1", src_data1, 16'h0000);
            check("reset_rd2", src_data2, 16'h0000);
        end

        // Directed table: outputs checked before the edge, then clocked.
        vecs[0]  = '{1'b0, 1'b1, 4'd3,  16'h0003, 4'd3,  4'd2,  16'h0003, 16'h0000};
        vecs[1]  = '{1'b0, 1'b1, 4'd3,  16'h00AB, 4'd3,  4'd2,  16'h00AB, 16'h0000};
        vecs[2]  = '{1'b0, 1'b0, 4'd3,  16'h0000, 4'd3,  4'd2,  16'h00AB, 16'h0000};
        vecs[3]  = '{1'b0, 1'b1, 4'd5,  16'h1111, 4'd5,  4'd5,  16'h1111, 16'h1111};
        vecs[4]  = '{1'b0, 1'b0, 4'd5,  16'hFFFF, 4'd5,  4'd3,  16'h1111, 16'h00AB};
        vecs[5]  = '{1'b0, 1'b0, 4'd5,  16'hFFFF, 4'd5,  4'd0,  16'h1111, 16'h0000};
        vecs[6]  = '{1'b0, 1'b1, 4'd0,  16'h1234, 4'd0,  4'd5,  16'h0000, 16'h1111};
        vecs[7]  = '{1'b0, 1'b0, 4'd0,  16'h0000, 4'd0,  4'd0,  16'h0000, 16'h0000};
        vecs[8]  = '{1'b1, 1'b1, 4'd7,  16'hBEEF, 4'd7,  4'd5,  16'hBEEF, 16'h1111};
        vecs[9]  = '{1'b0, 1'b0, 4'd7,  16'h0000, 4'd7,  4'd5,  16'h0000, 16'h0000};
        vecs[10] = '{1'b0, 1'b1, 4'd15, 16'h8001, 4'd14, 4'd15, 16'h0000, 16'h8001};
        vecs[11] = '{1'b0, 1'b0, 4'd15, 16'h0000, 4'd15, 4'd15, 16'h8001, 16'h8001};
        for (int v = 0; v < 12; v++) begin
            @(negedge clk);
            rst = vecs[v].rst; we = vecs[v].we; dst = vecs[v].dst;
            dat = vecs[v].dat; s1 = vecs[v].s1; s2 = vecs[v].s2;
            #1;
            check($sformatf("vec%0d_rd1", v), src_data1, vecs[v].e1);
            check($sformatf("vec%0d_rd2", v), src_data2, vecs[v].e2);
            @(posedge clk);
            ref_commit();
        end

        // Fill R[i]=i, then read back pairs with WriteReg low.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rst = 1'b0; we = 1'b1; dst = 4'(i); dat = 16'(i);
            @(posedge clk);
            ref_commit();
        end
        @(negedge clk);
        we = 1'b0;
        for (int i = 0; i < 16; i += 2) begin
            s1 = 4'(i);
            s2 = 4'(i + 1);
            #1;
            check("fill_rd1", src_data1, (i == 0) ? 16'h0000 : 16'(i));
            check("fill_rd2", src_data2, 16'(i + 1));
        end

        // Randomized traffic against the reference model, including live DstData changes.
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 19) == 0);
            we  = $urandom_range(0, 1);
            dst = 4'($urandom_range(0, 15));
            dat = 16'($urandom);
            s1  = ($urandom_range(0, 2) == 0) ? dst : 4'($urandom_range(0, 15));
            s2  = ($urandom_range(0, 2) == 0) ? dst : 4'($urandom_range(0, 15));
            #1;
            check("rand_rd1", src_data1, ref_read(s1));
            check("rand_rd2", src_data2, ref_read(s2));
            dat = 16'($urandom);
            #1;
            check("rand_live_rd1", src_data1, ref_read(s1));
            check("rand_live_rd2", src_data2, ref_read(s2));
            @(posedge clk);
            ref_commit();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
